// File: rtl/map_generator.sv
// map_generator: walks every tile of the arena once in row-major order and emits one
// write per tile (wall / brick / empty) toward the map editor's write queue.
// Bricks are drawn from the 4-bit RNG stream; writes pause while the queue is full.
// Optional feature: define MAPGEN_SPAWN_CLEAR_EN to force the two spawn corners empty.
module map_generator #(
    parameter int unsigned COLS         = 15,
    parameter int unsigned ROWS         = 13,
    parameter int unsigned BRICK_THRESH = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [3:0] randhex,
    input  logic       full,
    output logic       WE,
    output logic [7:0] MapWriteAddr,
    output logic [7:0] MapWriteData,
    output logic       busy,
    output logic       done,
    output logic [7:0] brick_count
);

    localparam logic [7:0] LastRow = 8'(ROWS - 1);
    localparam logic [7:0] LastCol = 8'(COLS - 1);

    localparam logic [7:0] CodeEmpty = 8'h00;
    localparam logic [7:0] CodeWall  = 8'h01;
    localparam logic [7:0] CodeBrick = 8'h02;

    typedef enum logic [1:0] {StIdle, StGen, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] row_q, row_d;
    logic [7:0] col_q, col_d;
    logic [7:0] tile_q, tile_d;

    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] bcount_q, bcount_d;

    logic       is_border;
    logic       is_pillar;
    logic       is_spawn;
    logic       is_last;
    logic       is_brick;
    logic [7:0] tile_code;

    // Classify the tile currently pointed to by the counter.
    always_comb begin
        is_border = (row_q == 8'd0) || (row_q == LastRow) ||
                    (col_q == 8'd0) || (col_q == LastCol);
        // Only reached for interior tiles, so even/even means a pillar.
        is_pillar = !row_q[0] && !col_q[0];
`ifdef MAPGEN_SPAWN_CLEAR_EN
        // Top-left and bottom-right L-shaped spawn pockets.
        is_spawn  = ((row_q == 8'd1) && (col_q == 8'd1)) ||
                    ((row_q == 8'd1) && (col_q == 8'd2)) ||
                    ((row_q == 8'd2) && (col_q == 8'd1)) ||
                    ((row_q == 8'(ROWS - 2)) && (col_q == 8'(COLS - 2))) ||
                    ((row_q == 8'(ROWS - 2)) && (col_q == 8'(COLS - 3))) ||
                    ((row_q == 8'(ROWS - 3)) && (col_q == 8'(COLS - 2)));
`else
        is_spawn  = 1'b0;
`endif
        is_last   = (row_q == LastRow) && (col_q == LastCol);
        is_brick  = 1'b0;
        if (is_border || is_pillar) begin
            tile_code = CodeWall;
        end else if (is_spawn) begin
            tile_code = CodeEmpty;
        end else if ({28'd0, randhex} < BRICK_THRESH) begin
            tile_code = CodeBrick;
            is_brick  = 1'b1;
        end else begin
            tile_code = CodeEmpty;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from idle so runs never overlap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StGen;
            StGen:   if (!full && is_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / counter next values; everything the block drives is registered.
    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        tile_d   = tile_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bcount_d = bcount_q;
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d   = 1'b1;
                    row_d    = 8'd0;
                    col_d    = 8'd0;
                    tile_d   = 8'd0;
                    bcount_d = 8'd0;
                end
            end
            StGen: begin
                // full holds the counter, so randhex is simply not consumed while stalled.
                if (!full) begin
                    we_d   = 1'b1;
                    addr_d = tile_q;
                    data_d = tile_code;
                    tile_d = tile_q + 8'd1;
                    if (is_brick) begin
                        bcount_d = bcount_q + 8'd1;
                    end
                    if (col_q == LastCol) begin
                        col_d = 8'd0;
                        row_d = row_q + 8'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end
            StDone: begin
                // busy stays high through the done cycle and falls with it.
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Counter and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            row_q    <= 8'd0;
            col_q    <= 8'd0;
            tile_q   <= 8'd0;
            we_q     <= 1'b0;
            addr_q   <= 8'd0;
            data_q   <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcount_q <= 8'd0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            tile_q   <= tile_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bcount_q <= bcount_d;
        end
    end

    assign WE           = we_q;
    assign MapWriteAddr = addr_q;
    assign MapWriteData = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign brick_count  = bcount_q;

endmodule

// File: tb/tb_map_generator.sv
// Testbench for map_generator: scoreboard of expected tile writes per run,
// covering reset, constant RNG values around the brick threshold, stalls,
// an ignored mid-run start and a mid-run reset.
module tb_map_generator;

    localparam int COLS = 15;
    localparam int ROWS = 13;
    localparam int NT   = COLS * ROWS;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       start;
    logic [3:0] randhex;
    logic       full;
    logic       WE;
    logic [7:0] MapWriteAddr;
    logic [7:0] MapWriteData;
    logic       busy;
    logic       done;
    logic [7:0] brick_count;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    map_generator #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .BRICK_THRESH(10)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .randhex     (randhex),
        .full        (full),
        .WE          (WE),
        .MapWriteAddr(MapWriteAddr),
        .MapWriteData(MapWriteData),
        .busy        (busy),
        .done        (done),
        .brick_count (brick_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference tile code for (r, c) given a constant RNG value.
    function automatic logic [7:0] model_code(input int r, input int c, input logic [3:0] rh);
        if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) return 8'h01;
        if ((r % 2 == 0) && (c % 2 == 0)) return 8'h01;
`ifdef MAPGEN_SPAWN_CLEAR_EN
        if ((r == 1 && c == 1) || (r == 1 && c == 2) || (r == 2 && c == 1) ||
            (r == ROWS - 2 && c == COLS - 2) || (r == ROWS - 2 && c == COLS - 3) ||
            (r == ROWS - 3 && c == COLS - 2)) return 8'h00;
`endif
        return (rh < 4'd10) ? 8'h02 : 8'h00;
    endfunction

    // One generation run. stall_at: addr held off for 5 cycles; start_at: addr at which
    // a stray start is pulsed; reset_at: addr at which Reset is pulsed (-1 disables each).
    task automatic run_map(input logic [3:0] rh, input int stall_at, input int start_at,
                           input int reset_at);
        int   exp_bricks = 0;
        int   writes     = 0;
        int   idle_busy  = 0;
        int   dones      = 0;
        int   stall_left = 0;
        int   bad_cover  = 0;
        int   hits[NT];
        bit   finished   = 1'b0;
        logic prev_we    = 1'b0;
        logic [7:0] prev_addr = 8'd0;
        logic [7:0] code;
        wr_t  e;

        foreach (hits[i]) hits[i] = 0;
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                code = model_code(r, c, rh);
                if (code == 8'h02) exp_bricks++;
                exp_q.push_back('{addr: 8'(r * COLS + c), data: code});
            end
        end

        randhex = rh;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("no_we_first_cycle", WE, 0);
        check("bcount_cleared", brick_count, 0);

        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            @(negedge Clk);
            start = 1'b0;
            if (WE) begin
                writes++;
                if (MapWriteAddr < NT) hits[MapWriteAddr]++;
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("addr", MapWriteAddr, e.addr);
                    check("data", MapWriteData, e.data);
                end
            end else if (busy && !done) begin
                idle_busy++;
            end

            if (done) begin
                dones++;
                check("done_after_last_we", {prev_we, prev_addr}, {1'b1, 8'(NT - 1)});
                check("brick_count", brick_count, exp_bricks);
                check("busy_with_done", busy, 1);
                @(negedge Clk);
                check("done_one_cycle", done, 0);
                check("busy_dropped", busy, 0);
                check("no_we_after_done", WE, 0);
                finished = 1'b1;
            end else begin
                if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) full = 1'b0;
                end
                if (WE && int'(MapWriteAddr) == stall_at - 1) begin
                    full       = 1'b1;
                    stall_left = 5;
                end
                if (WE && int'(MapWriteAddr) == start_at) start = 1'b1;
                if (WE && int'(MapWriteAddr) == reset_at) begin
                    Reset = 1'b1;
                    @(negedge Clk);
                    Reset = 1'b0;
                    check("rst_we", WE, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_addr", MapWriteAddr, 0);
                    check("rst_data", MapWriteData, 0);
                    check("rst_bcount", brick_count, 0);
                    finished = 1'b1;
                end
            end
            prev_we   = WE;
            prev_addr = MapWriteAddr;
        end

        full  = 1'b0;
        start = 1'b0;
        check("run_terminated", finished, 1);
        if (reset_at < 0) begin
            foreach (hits[i]) if (hits[i] != 1) bad_cover++;
            check("write_count", writes, NT);
            check("addr_each_once", bad_cover, 0);
            check("stall_cycles", idle_busy, (stall_at >= 0) ? 5 : 0);
            check("done_pulses", dones, 1);
            check("scoreboard_empty", exp_q.size(), 0);
        end
        exp_q.delete();
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        Reset   = 1'b1;
        start   = 1'b1;
        full    = 1'b0;
        randhex = 4'd0;
        repeat (2) begin
            @(negedge Clk);
            check("rst_hold_we", WE, 0);
            check("rst_hold_busy", busy, 0);
        end
        check("reset_addr", MapWriteAddr, 0);
        check("reset_data", MapWriteData, 0);
        check("reset_done", done, 0);
        check("reset_bcount", brick_count, 0);
        Reset = 1'b0;
        start = 1'b0;
        @(negedge Clk);
        check("idle_after_reset", busy, 0);

        run_map(4'd0, -1, -1, -1);   // every eligible tile a brick
        run_map(4'd15, -1, -1, -1);  // no bricks at all
        run_map(4'd9, 40, -1, -1);   // just under threshold, with a stall before addr 40
        run_map(4'd10, -1, 100, -1); // at threshold (empty), stray start mid-run
        run_map(4'd0, -1, -1, 50);   // reset mid-run
        run_map(4'd0, -1, -1, -1);   // clean restart after the aborted run

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
